// File: rtl/pixie_dma_fetch_if.sv
// pixie_dma_fetch_if: CPU bus, line-buffer read and status signals of the Pixie DMA fetch stage.
// frame_sum exists only when PIXIE_DMA_CHECKSUM_EN is defined.
interface pixie_dma_fetch_if;
  logic clk_enable;
  logic [1:0] SC;
  logic [7:0] data_in;
  logic display_en;
  logic frame_start;
  logic line_start;
  logic DMAO;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic line_ready;
  logic [7:0] line_cnt;
  logic [4:0] row_cnt;
  logic overrun;
  logic timeout_err;
`ifdef PIXIE_DMA_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif
  modport master (
    output clk_enable, SC, data_in, display_en, frame_start, line_start, rd_addr,
    input DMAO, rd_data, line_ready, line_cnt, row_cnt, overrun, timeout_err
`ifdef PIXIE_DMA_CHECKSUM_EN
    , frame_sum
`endif
  );
  modport slave (
    input clk_enable, SC, data_in, display_en, frame_start, line_start, rd_addr,
    output DMAO, rd_data, line_ready, line_cnt, row_cnt, overrun, timeout_err
`ifdef PIXIE_DMA_CHECKSUM_EN
    , frame_sum
`endif
  );
endinterface

// File: rtl/pixie_dma_fetch.sv
// pixie_dma_fetch: CDP1802 DMA-out line fetch into a ping-pong line buffer, with frame/line/row tracking.
// Define PIXIE_DMA_CHECKSUM_EN to add the per-frame byte checksum output frame_sum.
module pixie_dma_fetch #(
  parameter int BYTES_PER_LINE = 8,
  parameter int LINE_REPEAT = 4,
  parameter int ACTIVE_LINES = 128,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset_n,
  pixie_dma_fetch_if.slave bus
);
  localparam int IW = $clog2(BYTES_PER_LINE);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic wr_bank;
  logic [7:0] mem [2][BYTES_PER_LINE];
  logic busy, dma, go, keep, cap, fin, tmo, ovr, adv;
`ifdef PIXIE_DMA_CHECKSUM_EN
  logic [15:0] line_sum, acc;
`endif
  always_comb begin
    busy = state == REQ || state == CAPTURE;
    dma = bus.clk_enable && bus.SC == 2'b10;
    go = bus.line_start && bus.display_en;
    keep = busy && !bus.frame_start && bus.display_en;
    ovr = busy && go && !bus.frame_start;
    cap = keep && !go && dma;
    fin = cap && idx == IW'(BYTES_PER_LINE - 1);
    tmo = keep && !go && bus.clk_enable && !dma && tcnt == TW'(TIMEOUT - 1);
    adv = state == DONE || tmo;
    state_nx = go ? REQ : cap ? (fin ? DONE : CAPTURE) : (keep && !tmo) ? state : IDLE;
  end
  assign bus.DMAO = !(state == REQ || state == CAPTURE);
  assign bus.row_cnt = 5'(bus.line_cnt / 8'(LINE_REPEAT));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      tcnt <= '0;
      wr_bank <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < BYTES_PER_LINE; i++) mem[b][i] <= '0;
      bus.rd_data <= '0;
      bus.line_ready <= 1'b0;
      bus.line_cnt <= '0;
      bus.overrun <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        idx <= '0;
        tcnt <= '0;
      end else if (cap) begin
        mem[wr_bank][idx] <= bus.data_in;
        idx <= idx + 1'b1;
        tcnt <= '0;
      end else if (busy && bus.clk_enable) tcnt <= tcnt + 1'b1;
      if (fin) wr_bank <= !wr_bank;
      bus.line_ready <= fin;
      bus.overrun <= bus.overrun | ovr;
      bus.timeout_err <= bus.timeout_err | tmo;
      bus.line_cnt <= bus.frame_start ? '0 : !adv ? bus.line_cnt :
                      bus.line_cnt == 8'(ACTIVE_LINES - 1) ? '0 : bus.line_cnt + 8'd1;
      bus.rd_data <= mem[!wr_bank][bus.rd_addr];
    end
  end
`ifdef PIXIE_DMA_CHECKSUM_EN
  // Bytes are summed per line and folded into the frame total only when the line completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_sum <= '0;
      acc <= '0;
      bus.frame_sum <= '0;
    end else begin
      line_sum <= go ? '0 : cap ? line_sum + 16'(bus.data_in) : line_sum;
      if (bus.frame_start) begin
        bus.frame_sum <= acc;
        acc <= '0;
      end else if (fin) acc <= acc + line_sum + 16'(bus.data_in);
    end
  end
`endif
endmodule

// File: tb/tb_pixie_dma_fetch.sv
// tb_pixie_dma_fetch: directed bench; line-buffer reads are checked by a scoreboard monitor, status by direct checks.
module tb_pixie_dma_fetch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  pixie_dma_fetch_if bus();
  pixie_dma_fetch dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int lr_cnt = 0;
  int lr_base;
  logic [7:0] exp_q[$];
  logic [2:0] addr_q[$];
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  always @(posedge clk) rd_vld <= rd_req;
  always @(negedge clk) begin
    logic [7:0] e;
    logic [2:0] a;
    if (bus.line_ready) lr_cnt++;
    if (rd_vld) begin
      n_chk++;
      if (exp_q.size() == 0) $display("FAIL rd_data: unexpected read, got %h", bus.rd_data);
      else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (bus.rd_data === e) n_pass++;
        else $display("FAIL rd_data[%0d]: got %h want %h", a, bus.rd_data, e);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic dma(input logic [7:0] b);
    bus.clk_enable = 1'b1;
    bus.SC = 2'b10;
    bus.data_in = b;
    tick();
    bus.clk_enable = 1'b0;
    bus.SC = 2'b00;
  endtask
  task automatic start();
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    bus.rd_addr = a;
    rd_req = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    rd_req = 1'b0;
  endtask
  initial begin
    bus.clk_enable = 1'b0;
    bus.SC = 2'b00;
    bus.data_in = '0;
    bus.display_en = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_start = 1'b0;
    bus.rd_addr = '0;
    repeat (3) tick();
    chk("rst DMAO", 32'(bus.DMAO), 1);
    chk("rst line_ready", 32'(bus.line_ready), 0);
    chk("rst rd_data", 32'(bus.rd_data), 0);
    chk("rst line_cnt", 32'(bus.line_cnt), 0);
    chk("rst row_cnt", 32'(bus.row_cnt), 0);
    chk("rst overrun", 32'(bus.overrun), 0);
    chk("rst timeout_err", 32'(bus.timeout_err), 0);
    reset_n = 1'b1;
    tick();
    bus.display_en = 1'b1;
    start();
    chk("line DMAO low", 32'(bus.DMAO), 0);
    for (int i = 0; i < 8; i++) begin
      dma(8'(8'h11 * (i + 1)));
      if (i == 6) chk("line DMAO before last", 32'(bus.DMAO), 0);
    end
    chk("line DMAO released", 32'(bus.DMAO), 1);
    chk("line line_ready", 32'(bus.line_ready), 1);
    tick();
    chk("line line_cnt", 32'(bus.line_cnt), 1);
    chk("line line_ready pulse", 32'(bus.line_ready), 0);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'(8'h11 * (i + 1)));
    chk("line ready count", lr_cnt, 1);
    start();
    repeat (8) dma(8'hAA);
    tick();
    start();
    repeat (4) dma(8'h55);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'hAA);
    repeat (4) dma(8'h55);
    tick();
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h55);
    chk("pingpong line_cnt", 32'(bus.line_cnt), 3);
    chk("pingpong ready count", lr_cnt, 3);
    start();
    for (int i = 0; i < 3; i++) dma(8'(i + 1));
    chk("ovr flag before", 32'(bus.overrun), 0);
    start();
    chk("ovr flag", 32'(bus.overrun), 1);
    chk("ovr DMAO", 32'(bus.DMAO), 0);
    chk("ovr no ready", lr_cnt, 3);
    for (int i = 0; i < 8; i++) dma(8'(8'hC0 + i));
    tick();
    chk("ovr line_cnt", 32'(bus.line_cnt), 4);
    chk("ovr ready count", lr_cnt, 4);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'(8'hC0 + i));
    start();
    bus.SC = 2'b00;
    for (int i = 0; i < 16; i++) begin
      bus.clk_enable = 1'b1;
      tick();
      if (i == 14) begin
        chk("tmo early flag", 32'(bus.timeout_err), 0);
        chk("tmo early DMAO", 32'(bus.DMAO), 0);
      end
    end
    bus.clk_enable = 1'b0;
    chk("tmo flag", 32'(bus.timeout_err), 1);
    chk("tmo DMAO", 32'(bus.DMAO), 1);
    chk("tmo line_cnt", 32'(bus.line_cnt), 5);
    tick();
    chk("tmo no ready", lr_cnt, 4);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'(8'hC0 + i));
    start();
    repeat (2) dma(8'h77);
    bus.display_en = 1'b0;
    tick();
    chk("den drop DMAO", 32'(bus.DMAO), 1);
    start();
    chk("den off start DMAO", 32'(bus.DMAO), 1);
    chk("den line_cnt", 32'(bus.line_cnt), 5);
    bus.display_en = 1'b1;
    start();
    repeat (3) dma(8'h01);
    bus.frame_start = 1'b1;
    bus.line_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.line_start = 1'b0;
    chk("fs+ls line_cnt", 32'(bus.line_cnt), 0);
    chk("fs+ls DMAO", 32'(bus.DMAO), 0);
    chk("fs sticky overrun", 32'(bus.overrun), 1);
    repeat (8) dma(8'h01);
    tick();
    chk("wrap line 1", 32'(bus.line_cnt), 1);
    lr_base = lr_cnt;
    for (int n = 2; n <= 128; n++) begin
      start();
      repeat (8) dma(8'h01);
      tick();
      chk($sformatf("wrap line_cnt %0d", n), 32'(bus.line_cnt), 32'(n % 128));
      chk($sformatf("wrap row_cnt %0d", n), 32'(bus.row_cnt), 32'((n % 128) / 4));
      if (n == 127) chk("wrap row 31", 32'(bus.row_cnt), 31);
    end
    chk("wrap ready count", lr_cnt - lr_base, 127);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("frame line_cnt", 32'(bus.line_cnt), 0);
`ifdef PIXIE_DMA_CHECKSUM_EN
    chk("frame_sum", 32'(bus.frame_sum), 1024);
`endif
    start();
    for (int i = 0; i < 5; i++) dma(8'(8'hE0 + i));
    chk("mid DMAO low", 32'(bus.DMAO), 0);
    #2 reset_n = 1'b0;
    #1 chk("async DMAO", 32'(bus.DMAO), 1);
    chk("async line_ready", 32'(bus.line_ready), 0);
    chk("async rd_data", 32'(bus.rd_data), 0);
    chk("async overrun", 32'(bus.overrun), 0);
    chk("async timeout_err", 32'(bus.timeout_err), 0);
    chk("async line_cnt", 32'(bus.line_cnt), 0);
    chk("async row_cnt", 32'(bus.row_cnt), 0);
`ifdef PIXIE_DMA_CHECKSUM_EN
    chk("async frame_sum", 32'(bus.frame_sum), 0);
`endif
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00);
    tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
